// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_pkg                                                          |
// | Brief   : Shared funct3 encodings, FSM states and alignment helpers.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Unassigned encodings count as misaligned so they never touch memory.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Lane offset actually used: halfwords drop bit 0, words (and unassigned codes) use lane 0.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] eff;
    case (f3[1:0])
      2'b00:   eff = off;
      2'b01:   eff = {off[1], 1'b0};
      default: eff = 2'b00;
    endcase
    return eff;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_rmw_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_rmw_if                                                       |
// | Brief   : Pipeline request/response and data-memory bus of the LSU.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lsu_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_align                                                        |
// | Brief   : Combinational lane extract/extend (loads) and merge (stores).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  assign w_byte   = word_i[{off_i, 3'b000} +: 8];
  assign w_half   = off_i[1] ? word_i[31:16] : word_i[15:0];
  assign w_signed = ~funct3_i[2];

  always_comb begin
    rdata_o  = word_i;
    merged_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        rdata_o  = {{24{w_byte[7] & w_signed}}, w_byte};
        merged_o = word_i;
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      2'b01: begin
        rdata_o  = {{16{w_half[15] & w_signed}}, w_half};
        merged_o = word_i;
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        rdata_o  = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_rmw                                                          |
// | Brief   : Load/store unit; sub-word stores as read-modify-write.           |
// |           Macro LSU_MISALIGN_CHECK_EN enables misalignment errors.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_rmw_if.slave     bus
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              w_idle;
  logic              w_accept;
  logic [2:0]        w_f3;
  logic [1:0]        w_off_raw;
  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_addr_src;
  logic              w_err;
  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_merged;

  // In IDLE the live request steers the aligner; afterwards the captured op does.
  assign w_idle     = (state_q == IDLE);
  assign w_accept   = w_idle & bus.req_valid;
  assign w_f3       = w_idle ? bus.req_funct3 : f3_q;
  assign w_off_raw  = w_idle ? bus.req_addr[1:0] : addr_q[1:0];
  assign w_off      = eff_offset(w_f3, w_off_raw);
  assign w_wdata    = w_idle ? bus.req_wdata : wdata_q;
  assign w_addr_src = w_accept ? bus.req_addr : addr_q;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_err = is_misaligned(w_f3, w_off_raw);
`else
  assign w_err = 1'b0;
`endif

  lsu_align u_align (
    .word_i   (bus.mem_rd_data),
    .wdata_i  (w_wdata),
    .funct3_i (w_f3),
    .off_i    (w_off),
    .rdata_o  (w_ld_data),
    .merged_o (w_merged)
  );

  assign bus.req_ready   = w_idle;
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.mem_we      = (state_q == WRITE);
  assign bus.mem_addr    = {w_addr_src[ADDR_W-1:2], 2'b00};
  assign bus.mem_wr_data = merge_q;

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = w_err;
          rdata_d = (!bus.req_we && !w_err) ? w_ld_data : '0;
          if (w_err || !bus.req_we) begin
            state_d = RESP;
          end else if (w_f3[1]) begin
            merge_d = w_merged;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        merge_d = w_merged;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lsu_rmw                                                       |
// | Brief   : Directed scoreboard bench for lsu_rmw with a word memory model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lsu_rmw;
  import lsu_pkg::*;

  typedef struct packed { logic [31:0] rd; logic err; } resp_t;
  typedef struct packed { logic [31:0] a;  logic [31:0] d; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  logic [31:0] mem [0:15];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  always #5 clk = ~clk;

  lsu_rmw_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_rd_data = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (bus.mem_we)   mem[bus.mem_addr[5:2]] <= bus.mem_wr_data;
    else if (poke_en) mem[poke_idx] <= poke_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Write and response monitor: pops expectations as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, w.a);
          check("wr_data", bus.mem_wr_data, w.d);
        end
      end
      if (bus.resp_valid) begin
        check("resp_expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, r.rd);
          check("resp_err", 32'(bus.resp_err), 32'(r.err));
        end
      end
    end
  end

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                    input logic exp_wr, input logic [31:0] exp_wa, input logic [31:0] exp_wd);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    resp_q.push_back('{rd: exp_rd, err: exp_err});
    if (exp_wr) wr_q.push_back('{a: exp_wa, d: exp_wd});
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = $urandom_range(0, 1) != 0;
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    end while (!bus.resp_valid && lat < 12);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) poke(4'(i), 32'h0);
    poke(4'd0, 32'hA0B0_C0D0);
    poke(4'd1, 32'h80FF_1234);
    poke(4'd3, 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wr_data", bus.mem_wr_data, 32'd0);

    op("lb",  1'b0, F3_B,  32'h7, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lhu", 1'b0, F3_HU, 32'h6, 32'h0, 32'h0000_80FF, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lh",  1'b0, F3_H,  32'h6, 32'h0, 32'hFFFF_80FF, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lbu", 1'b0, F3_BU, 32'h4, 32'h0, 32'h0000_0034, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lb5", 1'b0, F3_B,  32'h5, 32'h0, 32'h0000_0012, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lw",  1'b0, F3_W,  32'h4, 32'h0, 32'h80FF_1234, 1'b0, 1, 1'b0, 32'h0, 32'h0);

    poke(4'd1, 32'h1122_3344);
    op("sb",  1'b1, F3_B, 32'h5, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b1, 32'h4, 32'h1122_AB44);
    op("sw",  1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, 32'h8, 32'hDEAD_BEEF);
    op("lw8", 1'b0, F3_W, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 32'h0, 32'h0);

`ifdef LSU_MISALIGN_CHECK_EN
    op("sh_mis",  1'b1, F3_H,   32'h3, 32'h5566, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0);
    op("lw0",     1'b0, F3_W,   32'h0, 32'h0, 32'hA0B0_C0D0, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("ld_inv",  1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0);
    op("lw_mis",  1'b0, F3_W,   32'h6, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0);
`else
    op("sh_mis",  1'b1, F3_H,   32'h3, 32'h5566, 32'h0, 1'b0, 3, 1'b1, 32'h0, 32'h5566_C0D0);
    op("lw0",     1'b0, F3_W,   32'h0, 32'h0, 32'h5566_C0D0, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("ld_inv",  1'b0, 3'b011, 32'h4, 32'h0, 32'h1122_AB44, 1'b0, 1, 1'b0, 32'h0, 32'h0);
    op("lw_mis",  1'b0, F3_W,   32'h6, 32'h0, 32'h1122_AB44, 1'b0, 1, 1'b0, 32'h0, 32'h0);
`endif
    op("lhu_c",  1'b0, F3_HU, 32'hE, 32'h0, 32'h0000_CAFE, 1'b0, 1, 1'b0, 32'h0, 32'h0);

    // Reset lands in the READ cycle of an SH; no expectation is queued for it.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'hE; bus.req_wdata = 32'h1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("mid_rst_mem_wr_data", bus.mem_wr_data, 32'd0);
    check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("in_rst_mem_we", 32'(bus.mem_we), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_mem_we", 32'(bus.mem_we), 32'd0);
    end
    check("post_rst_mem3", mem[3], 32'hCAFE_F00D);
    op("lhu_post", 1'b0, F3_HU, 32'hE, 32'h0, 32'h0000_CAFE, 1'b0, 1, 1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the MEM-stage pipeline register and the word-aligned data memory. The memory has combinational read, synchronous write, and word-granular write only.
- Loads: the unit extracts bytes/halfwords and sign- or zero-extends them.
- Stores: the unit turns SB/SH into a two-cycle read-modify-write and SW into a single registered write.
- Handshakes with the pipeline so hazard control can stall the stage while busy.

Parameters:
- ADDR_W, 32, byte-address width to memory
- DATA_W, 32, word width; fixed at 32 (RV32)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents a memory op
- req_ready  out  1  unit accepts op this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle pulse: op complete
- resp_rdata  out  DATA_W  extended load result; 0 for stores
- resp_err  out  1  misaligned access, qualified by resp_valid
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory, bits [1:0] always 0
- mem_wr_data  out  DATA_W  to memory write data
- mem_rd_data  in  DATA_W  from memory, combinational read

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - state=IDLE
  - resp_valid=0, resp_rdata=0, resp_err=0
  - mem_we=0, mem_addr=0, mem_wr_data=0
  - all capture registers 0
- Handshake: req_ready=1 only in IDLE. An op is accepted when req_valid & req_ready. The op is then captured (we, funct3, addr, wdata).
- Loads:
  - mem_addr = {req_addr[31:2],2'b00} combinationally in IDLE, so the read happens in the accept cycle.
  - Lane is selected by addr[1:0]: byte lane addr[1:0]; half lane addr[1].
  - Result is extended and registered. resp_valid is asserted the cycle after accept (latency 1).
- States:
  - IDLE: load -> RESP; SW -> WRITE; SB/SH -> READ; misaligned -> RESP with err.
  - READ: drive captured word address; latch mem_rd_data merged with the store byte/half into the merge register -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle, mem_wr_data = merged word (SW: wdata as-is) -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. req_ready stays 0 in RESP; the next op is accepted in the following cycle.
- Latency (accept to resp_valid, inclusive of the RESP cycle):
  - load 1 cycle
  - SW 2 cycles
  - SB/SH 3 cycles
  - misaligned 1 cycle
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. These never assert mem_we, and set resp_err=1, resp_rdata=0.
- Invalid funct3 (011, 110, 111): treated as misaligned (resp_err=1), no memory write.
- Outside WRITE: mem_we=0. mem_wr_data holds its last value.
- Reset asserted mid-RMW: state returns to IDLE immediately. A pending write is abandoned; memory is never partially written.
- req_* changing while not ready: ignored; only captured values are used.
- Address wrap: no increment is performed, so there is no wrap case. addr[ADDR_W-1:2] passes through unchanged.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: misalignment detection and resp_err as above.
- Undefined:
  - resp_err tied 0.
  - Halfword ops force addr[0]=0; word ops use addr[1:0]=00, i.e. silent truncation.
  - Every valid funct3 accesses memory.
  - Invalid funct3 behaves as LW/SW.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams/enum (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t {IDLE, READ, WRITE, RESP}
  - function is_misaligned(funct3, addr[1:0])
- Sub-module lsu_align, purely combinational:
  - load path: extract+extend(word, funct3, off) -> rdata
  - store path: merge(word, wdata, funct3, off) -> merged word
  - shared with any future cache path.

Test Plan:
- LB from addr 0x0000_0007, word at 0x4 = 0x80FF_1234 -> resp_valid 1 cycle after accept, resp_rdata=0xFFFF_FF80, mem_we never 1.
- LHU addr 0x6, same word -> resp_rdata=0x0000_80FF. Repeat with LH -> 0xFFFF_80FF.
- SB wdata=0xAB to addr 0x5, word 0x1122_3344:
  - req_ready low for 3 cycles.
  - mem_we high exactly once with mem_addr=0x4, mem_wr_data=0x1122_AB44.
  - resp_valid on the 3rd cycle.
- SW 0xDEAD_BEEF to 0x8 -> single mem_we cycle with data 0xDEAD_BEEF, resp_valid 2 cycles after accept. Then a back-to-back LW 0x8 -> 0xDEAD_BEEF.
- With LSU_MISALIGN_CHECK_EN, SH to 0x3 -> resp_err=1 after 1 cycle, mem_we stays 0. Without the macro -> writes halfword at offset 2.
- Assert rst_n low during READ of an SH:
  - outputs zero immediately, mem_we never asserted, state IDLE.
  - After release, req_ready=1 and memory contents unchanged.
